// File: rtl/obi_demux_pkg.sv
// Shared OBI bus configuration and default request/response types
// used by the demux and its neighbours in the crossbar.
package obi_demux_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef struct packed {
    bit          UseRReady;
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b0,
    AddrWidth: AddrWidth,
    DataWidth: DataWidth
  };

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
  } obi_default_a_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } obi_default_r_t;

  typedef struct packed {
    logic           req;
    obi_default_a_t a;
    logic           rready;
  } obi_default_req_t;

  typedef struct packed {
    logic           gnt;
    logic           rvalid;
    obi_default_r_t r;
  } obi_default_rsp_t;

endpackage

// File: rtl/obi_demux.sv
// OBI demultiplexer: routes one subordinate port to one of several
// manager ports, locking the route while transactions are in flight.
module obi_demux
  import obi_demux_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
  parameter type         obi_req_t   = obi_default_req_t,
  parameter type         obi_rsp_t   = obi_default_rsp_t,
  parameter int unsigned NumMstPorts = 32'd2,
  parameter int unsigned NumMaxTrans = 32'd2,
  parameter int unsigned SelectWidth = $clog2(NumMstPorts)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [SelectWidth-1:0] slv_port_select_i,
  input  obi_req_t               slv_port_obi_req_i,
  output obi_rsp_t               slv_port_obi_rsp_o,
  output obi_req_t               mst_ports_obi_req_o [NumMstPorts],
  input  obi_rsp_t               mst_ports_obi_rsp_i [NumMstPorts]
);

  localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumMaxTrans);

  if (NumMstPorts < 2) begin : g_bad_ports
    $fatal(1, "obi_demux: NumMstPorts must be >= 2");
  end
  if (NumMaxTrans < 1) begin : g_bad_trans
    $fatal(1, "obi_demux: NumMaxTrans must be >= 1");
  end

  logic [SelectWidth-1:0] select_q;
  logic [CntWidth-1:0]    cnt_q;
  logic [CntWidth-1:0]    cnt_d;
  logic                   stall;
  logic                   hs_a;
  logic                   hs_r;
  logic                   rready;

  assign stall = ((cnt_q != '0) && (slv_port_select_i != select_q))
              || (cnt_q == CntMax);

  always_comb begin
    for (int unsigned p = 0; p < NumMstPorts; p++) begin
      mst_ports_obi_req_o[p] = slv_port_obi_req_i;
      mst_ports_obi_req_o[p].req = slv_port_obi_req_i.req && !stall
        && (SelectWidth'(p) == slv_port_select_i);
      mst_ports_obi_req_o[p].rready = ObiCfg.UseRReady
        && slv_port_obi_req_i.rready
        && (SelectWidth'(p) == select_q);
    end
  end

  always_comb begin
    slv_port_obi_rsp_o = '0;
    slv_port_obi_rsp_o.gnt = mst_ports_obi_rsp_i[slv_port_select_i].gnt
      && slv_port_obi_req_i.req && !stall;
    slv_port_obi_rsp_o.rvalid = mst_ports_obi_rsp_i[select_q].rvalid;
    slv_port_obi_rsp_o.r = mst_ports_obi_rsp_i[select_q].r;
  end

  assign rready = ObiCfg.UseRReady ? slv_port_obi_req_i.rready : 1'b1;
  assign hs_a = slv_port_obi_req_i.req && slv_port_obi_rsp_o.gnt;
  assign hs_r = slv_port_obi_rsp_o.rvalid && rready;

  // A response with nothing outstanding saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    case ({hs_a, hs_r})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      select_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (hs_a) select_q <= slv_port_select_i;
    end
  end

  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    hs_r |-> (cnt_q != '0));

  a_select_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (slv_port_obi_req_i.req && !slv_port_obi_rsp_o.gnt)
      |=> $stable(slv_port_select_i));

endmodule

// File: tb/tb_obi_demux.sv
// Self-checking bench for obi_demux: directed scenarios plus a
// randomized run against a queue-free transaction-count model.
module tb_obi_demux;
  import obi_demux_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned M = 2;
  localparam obi_cfg_t Cfg = '{
    UseRReady: 1'b1,
    AddrWidth: AddrWidth,
    DataWidth: DataWidth
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sel;
  logic [31:0] salt;
  obi_default_req_t slv_req;
  obi_default_rsp_t slv_rsp;
  obi_default_req_t mst_req [N];
  obi_default_rsp_t mst_rsp [N];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  obi_demux #(
    .ObiCfg      (Cfg),
    .obi_req_t   (obi_default_req_t),
    .obi_rsp_t   (obi_default_rsp_t),
    .NumMstPorts (N),
    .NumMaxTrans (M)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .slv_port_select_i   (sel),
    .slv_port_obi_req_i  (slv_req),
    .slv_port_obi_rsp_o  (slv_rsp),
    .mst_ports_obi_req_o (mst_req),
    .mst_ports_obi_rsp_i (mst_rsp)
  );

  task automatic drive(input bit req, input int s,
                       input logic [31:0] addr,
                       input logic [3:0] gm,
                       input logic [3:0] rvm,
                       input bit rr);
    slv_req = '0;
    slv_req.req = req;
    slv_req.a.addr = addr;
    slv_req.a.we = addr[0];
    slv_req.a.be = 4'hf;
    slv_req.a.wdata = ~addr;
    slv_req.rready = rr;
    sel = s[1:0];
    for (int p = 0; p < N; p++) begin
      mst_rsp[p] = '0;
      mst_rsp[p].gnt = gm[p];
      mst_rsp[p].rvalid = rvm[p];
      mst_rsp[p].r.rdata = salt ^ 32'(p);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    salt = '0;
    drive(1'b0, 0, '0, 4'hf, 4'h0, 1'b1);
    #2;
    for (int p = 0; p < N; p++) begin
      n_checks++;
      if (mst_req[p].req !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_req[%0d]: got %b want 0", p, mst_req[p].req);
      end
    end
    n_checks++;
    if (slv_rsp.gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b want 0", slv_rsp.gnt);
    end
    n_checks++;
    if (slv_rsp.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid: got %b want 0", slv_rsp.rvalid);
    end
    n_checks++;
    if (slv_rsp.r.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want 0", slv_rsp.r.rdata);
    end
    n_checks++;
    if (dut.cnt_q !== 2'd0 || dut.select_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt %0d sel %0d want 0 0",
               dut.cnt_q, dut.select_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write;
    @(negedge clk);
    salt = $urandom;
    drive(1'b1, 2, 32'h1000_0041, 4'hf, 4'h0, 1'b1);
    #2;
    n_checks++;
    if (slv_rsp.gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_gnt: got %b want 1", slv_rsp.gnt);
    end
    for (int p = 0; p < N; p++) begin
      n_checks++;
      if (mst_req[p].req !== (p == 2)) begin
        n_fail++;
        $display("FAIL wr_req[%0d]: got %b want %b", p, mst_req[p].req, p == 2);
      end
    end
    n_checks++;
    if (mst_req[2].a.addr !== 32'h1000_0041) begin
      n_fail++;
      $display("FAIL wr_addr: got %h want 10000041", mst_req[2].a.addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dut.cnt_q !== 2'd1 || dut.select_q !== 2'd2) begin
      n_fail++;
      $display("FAIL wr_state: got cnt %0d sel %0d want 1 2",
               dut.cnt_q, dut.select_q);
    end
    @(negedge clk);
    drive(1'b0, 0, '0, 4'h0, 4'b0100, 1'b1);
    #2;
    n_checks++;
    if (slv_rsp.rvalid !== 1'b1 || slv_rsp.r.rdata !== (salt ^ 32'd2)) begin
      n_fail++;
      $display("FAIL wr_rsp: got %b %h want 1 %h",
               slv_rsp.rvalid, slv_rsp.r.rdata, salt ^ 32'd2);
    end
    n_checks++;
    if (mst_req[2].rready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rready: got %b want 1", mst_req[2].rready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dut.cnt_q !== 2'd0) begin
      n_fail++;
      $display("FAIL wr_cnt_end: got %0d want 0", dut.cnt_q);
    end
  endtask

  task automatic test_stall_full;
    logic [3:0] rv [5] = '{4'h0, 4'h0, 4'h0, 4'b0010, 4'h0};
    bit eg [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int ec [5] = '{1, 2, 2, 1, 2};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      salt = $urandom;
      drive(1'b1, 1, 32'h2000_0000 + 32'(c < 2 ? c : 2), 4'hf, rv[c], 1'b1);
      #2;
      n_checks++;
      if (slv_rsp.gnt !== eg[c] || mst_req[1].req !== eg[c]) begin
        n_fail++;
        $display("FAIL full_gnt c%0d: got gnt %b req %b want %b",
                 c, slv_rsp.gnt, mst_req[1].req, eg[c]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (dut.cnt_q !== 2'(ec[c])) begin
        n_fail++;
        $display("FAIL full_cnt c%0d: got %0d want %0d", c, dut.cnt_q, ec[c]);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b0, 0, '0, 4'h0, 4'b0010, 1'b1);
      @(posedge clk); #1;
    end
    n_checks++;
    if (dut.cnt_q !== 2'd0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d want 0", dut.cnt_q);
    end
  endtask

  task automatic test_port_switch;
    int s [4] = '{0, 3, 3, 3};
    logic [3:0] rv [4] = '{4'h0, 4'h0, 4'b0001, 4'h0};
    bit eg [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int ec [4] = '{1, 1, 0, 1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      salt = $urandom;
      drive(1'b1, s[c], 32'h3000_0000 + 32'(s[c]), 4'hf, rv[c], 1'b1);
      #2;
      n_checks++;
      if (slv_rsp.gnt !== eg[c] || mst_req[s[c]].req !== eg[c]) begin
        n_fail++;
        $display("FAIL switch_gnt c%0d: got gnt %b req %b want %b",
                 c, slv_rsp.gnt, mst_req[s[c]].req, eg[c]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (dut.cnt_q !== 2'(ec[c])) begin
        n_fail++;
        $display("FAIL switch_cnt c%0d: got %0d want %0d", c, dut.cnt_q, ec[c]);
      end
    end
    n_checks++;
    if (dut.select_q !== 2'd3) begin
      n_fail++;
      $display("FAIL switch_sel: got %0d want 3", dut.select_q);
    end
    @(negedge clk);
    drive(1'b0, 0, '0, 4'h0, 4'b1000, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    drive(1'b1, 1, 32'h4000_0000, 4'hf, 4'h0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    salt = $urandom;
    drive(1'b1, 1, 32'h4000_0004, 4'hf, 4'b0010, 1'b1);
    #2;
    n_checks++;
    if (slv_rsp.gnt !== 1'b1 || slv_rsp.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_hs: got gnt %b rvalid %b want 1 1",
               slv_rsp.gnt, slv_rsp.rvalid);
    end
    n_checks++;
    if (slv_rsp.r.rdata !== (salt ^ 32'd1)) begin
      n_fail++;
      $display("FAIL same_rdata: got %h want %h", slv_rsp.r.rdata, salt ^ 32'd1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dut.cnt_q !== 2'd1) begin
      n_fail++;
      $display("FAIL same_cnt: got %0d want 1", dut.cnt_q);
    end
    @(negedge clk);
    drive(1'b0, 0, '0, 4'h0, 4'b0010, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_rready;
    @(negedge clk);
    drive(1'b1, 2, 32'h5000_0000, 4'hf, 4'h0, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 0, '0, 4'h0, 4'b0100, c == 3);
      #2;
      n_checks++;
      if (mst_req[2].rready !== (c == 3) || slv_rsp.rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_out c%0d: got rready %b rvalid %b want %b 1",
                 c, mst_req[2].rready, slv_rsp.rvalid, c == 3);
      end
      @(posedge clk); #1;
      n_checks++;
      if (dut.cnt_q !== ((c == 3) ? 2'd0 : 2'd1)) begin
        n_fail++;
        $display("FAIL rr_cnt c%0d: got %0d want %0d", c, dut.cnt_q, c != 3);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b1, 1, 32'h6000_0000, 4'hf, 4'h0, 1'b1);
      @(posedge clk); #1;
    end
    n_checks++;
    if (dut.cnt_q !== 2'd2) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %0d want 2", dut.cnt_q);
    end
    @(negedge clk);
    salt = '0;
    drive(1'b0, 0, '0, 4'h0, 4'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut.cnt_q !== 2'd0 || dut.select_q !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_state: got cnt %0d sel %0d want 0 0",
               dut.cnt_q, dut.select_q);
    end
    for (int p = 0; p < N; p++) begin
      n_checks++;
      if (mst_req[p].req !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_req[%0d]: got %b want 0", p, mst_req[p].req);
      end
    end
    n_checks++;
    if (slv_rsp.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rvalid: got %b want 0", slv_rsp.rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    int outstanding = 0;
    int locked = 0;
    bit pending = 1'b0;
    int psel = 0;
    logic [31:0] paddr = '0;
    logic [3:0] gm, rvm;
    bit rr, stall, eg, hs_r;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!pending) begin
        pending = ($urandom % 3) != 0;
        psel = int'($urandom % N);
        paddr = $urandom;
      end
      gm = 4'($urandom);
      rr = ($urandom % 4) != 0;
      rvm = '0;
      if (outstanding > 0 && ($urandom % 2) == 1) rvm[locked] = 1'b1;
      salt = $urandom;
      drive(pending, psel, paddr, gm, rvm, rr);
      #2;
      stall = (outstanding != 0 && psel != locked) || outstanding == M;
      eg = pending && gm[psel] && !stall;
      hs_r = (rvm != 0) && rr;
      n_checks++;
      if (slv_rsp.gnt !== eg) begin
        n_fail++;
        $display("FAIL rnd_gnt i%0d: got %b want %b", i, slv_rsp.gnt, eg);
      end
      for (int p = 0; p < N; p++) begin
        n_checks++;
        if (mst_req[p].req !== (pending && !stall && p == psel)
            || mst_req[p].rready !== (rr && p == locked)) begin
          n_fail++;
          $display("FAIL rnd_port i%0d p%0d: got req %b rready %b", i, p,
                   mst_req[p].req, mst_req[p].rready);
        end
      end
      n_checks++;
      if (slv_rsp.rvalid !== (rvm != 0)
          || (rvm != 0 && slv_rsp.r.rdata !== (salt ^ 32'(locked)))) begin
        n_fail++;
        $display("FAIL rnd_rsp i%0d: got %b %h want %b %h", i, slv_rsp.rvalid,
                 slv_rsp.r.rdata, rvm != 0, salt ^ 32'(locked));
      end
      @(posedge clk); #1;
      if (eg) begin
        outstanding++;
        locked = psel;
        pending = 1'b0;
      end
      if (hs_r) outstanding--;
      n_checks++;
      if (dut.cnt_q !== 2'(outstanding)) begin
        n_fail++;
        $display("FAIL rnd_cnt i%0d: got %0d want %0d", i, dut.cnt_q, outstanding);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stall_full();
    test_port_switch();
    test_same_cycle();
    test_rready();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
